// File: rtl/nes_dma_pkg.sv
// Shared definitions for the multi-channel NES DMA engine: state encoding,
// CPU-cycle parity values and the default block-copy destination.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_BLK_RD = 3'd3,
        ST_BLK_WR = 3'd4,
        ST_REQ_RD = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Parity of a CPU cycle: reads ("get") belong on even cycles.
    localparam logic PAR_GET = 1'b0;
    localparam logic PAR_PUT = 1'b1;

    // OAMDATA-style write target of the block copy.
    localparam logic [15:0] DEF_BLK_DST = 16'h2004;

    // Width of an index over n channels (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nes_dma_arb.sv
// Fixed-priority arbiter: the lowest-index asserted request wins.
module nes_dma_arb
    import nes_dma_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    // Scan from the highest index down so the lowest asserted index is kept last.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel   = SEL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nes_dma_multi.sv
// Block-copy plus multi-channel single-byte fetch DMA engine. Halts the CPU,
// optionally aligns reads to get cycles, and lets fetch channels preempt the
// block copy between its read/write pairs.
module nes_dma_multi
    import nes_dma_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter int                NUM_REQ   = 2,
    parameter int                BLK_LEN   = 256,
    parameter logic [ADDR_W-1:0] BLK_DST   = ADDR_W'(DEF_BLK_DST),
    parameter int                ALIGN_GET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_clk,
    input  logic                      blk_trig,
    input  logic [ADDR_W-9:0]         blk_page,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      cpu_r_nw,
    input  logic [DATA_W-1:0]         from_ram,
    output logic [ADDR_W-1:0]         a_out,
    output logic                      dma_active,
    output logic                      cpu_ready,
    output logic                      dma_r_nw,
    output logic [DATA_W-1:0]         to_ram,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_data,
    output logic                      blk_busy
);

    localparam int CNT_W = $clog2(BLK_LEN);
    localparam int SEL_W = idx_w(NUM_REQ);

    state_t               state_reg;
    logic                 parity_reg;   // parity of the CPU cycle starting at the next cpu_clk
    logic [ADDR_W-9:0]    page_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [SEL_W-1:0]     sel_reg;

    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   req_mask;
    logic [SEL_W-1:0]     arb_sel;
    logic                 arb_valid;
    logic                 last_pair;
    logic                 busy_next;
    state_t               target;
    logic [7:0]           cnt_lo;

    // Split the flat address bus into one address per channel.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign cnt_lo    = 8'(cnt_reg);
    assign last_pair = (cnt_reg == CNT_W'(BLK_LEN - 1));

    // The channel being served right now still holds req; keep it out of the
    // next arbitration so it cannot be acked twice.
    always_comb begin
        req_mask = req;
        if (state_reg == ST_REQ_RD) begin
            req_mask[sel_reg] = 1'b0;
        end
    end

    nes_dma_arb #(
        .N     (NUM_REQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .req   (req_mask),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    // Next bus activity: fetches first, then the block copy, else release the CPU.
    always_comb begin
        busy_next = blk_busy;
        if (state_reg == ST_BLK_WR && last_pair) begin
            busy_next = 1'b0;
        end
        if (arb_valid) begin
            target = ST_REQ_RD;
        end else if (busy_next) begin
            target = ST_BLK_RD;
        end else begin
            target = ST_DONE;
        end
    end

    // FSM: state and data latches advance on cpu_clk; bus outputs are
    // re-registered every clk from the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            parity_reg <= PAR_GET;
            page_reg   <= '0;
            cnt_reg    <= '0;
            sel_reg    <= '0;
            blk_busy   <= 1'b0;
            to_ram     <= '0;
            req_data   <= '0;
            a_out      <= '0;
            dma_active <= 1'b0;
            cpu_ready  <= 1'b1;
            dma_r_nw   <= 1'b1;
            req_ack    <= '0;
        end else begin
            a_out      <= '0;
            dma_active <= 1'b0;
            cpu_ready  <= 1'b0;
            dma_r_nw   <= 1'b1;
            req_ack    <= '0;
            case (state_reg)
                ST_IDLE, ST_DONE: cpu_ready <= 1'b1;
                ST_BLK_RD: begin
                    a_out      <= {page_reg, cnt_lo};
                    dma_active <= 1'b1;
                end
                ST_BLK_WR: begin
                    a_out      <= BLK_DST;
                    dma_active <= 1'b1;
                    dma_r_nw   <= 1'b0;
                end
                ST_REQ_RD: begin
                    a_out      <= addr_arr[sel_reg];
                    dma_active <= 1'b1;
                    req_ack    <= NUM_REQ'(1) << sel_reg;
                end
                default: ;
            endcase

            if (cpu_clk) begin
                parity_reg <= ~parity_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (blk_trig && !blk_busy) begin
                            page_reg <= blk_page;
                            cnt_reg  <= '0;
                            blk_busy <= 1'b1;
                        end
                        if (blk_trig || (|req)) begin
                            state_reg <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (cpu_r_nw) begin
                            if ((ALIGN_GET != 0) && (parity_reg == PAR_PUT)) begin
                                state_reg <= ST_ALIGN;
                            end else begin
                                state_reg <= target;
                                sel_reg   <= arb_sel;
                            end
                        end
                    end
                    ST_ALIGN: begin
                        state_reg <= target;
                        sel_reg   <= arb_sel;
                    end
                    ST_BLK_RD: begin
                        to_ram    <= from_ram;
                        state_reg <= ST_BLK_WR;
                    end
                    ST_BLK_WR: begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        blk_busy  <= busy_next;
                        state_reg <= target;
                        sel_reg   <= arb_sel;
                    end
                    ST_REQ_RD: begin
                        req_data  <= from_ram;
                        state_reg <= target;
                        sel_reg   <= arb_sel;
                    end
                    ST_DONE: begin
                        if (cpu_r_nw) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nes_dma_multi.sv
// Directed bench for nes_dma_multi: block copy, fetches, preemption,
// priority, halt/done waiting and reset mid-copy.
module tb_nes_dma_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_clk;
    logic        blk_trig;
    logic [7:0]  blk_page;
    logic [1:0]  req;
    logic [31:0] req_addr;
    logic        cpu_r_nw;
    logic [7:0]  from_ram;
    logic [15:0] a_out;
    logic        dma_active;
    logic        cpu_ready;
    logic        dma_r_nw;
    logic [7:0]  to_ram;
    logic [1:0]  req_ack;
    logic [7:0]  req_data;
    logic        blk_busy;

    int checks;
    int errors;
    int edge_n;     // cpu_clk pulses since reset release; even => next cycle is GET

    always #5 clk = ~clk;

    nes_dma_multi dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_clk    (cpu_clk),
        .blk_trig   (blk_trig),
        .blk_page   (blk_page),
        .req        (req),
        .req_addr   (req_addr),
        .cpu_r_nw   (cpu_r_nw),
        .from_ram   (from_ram),
        .a_out      (a_out),
        .dma_active (dma_active),
        .cpu_ready  (cpu_ready),
        .dma_r_nw   (dma_r_nw),
        .to_ram     (to_ram),
        .req_ack    (req_ack),
        .req_data   (req_data),
        .blk_busy   (blk_busy)
    );

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        if (a == 16'hC000) return 8'h5A;
        if (a == 16'hC123) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always_comb from_ram = ram_byte(a_out);

    // One CPU cycle: pulse cpu_clk for one clk, then let the registered outputs settle.
    task automatic tick();
        cpu_clk = 1'b1;
        @(negedge clk);
        cpu_clk = 1'b0;
        @(negedge clk);
        edge_n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (a_out !== 16'h0 || dma_active !== 1'b0 || cpu_ready !== 1'b1 || dma_r_nw !== 1'b1 ||
            req_ack !== 2'b00 || req_data !== 8'h0 || to_ram !== 8'h0 || blk_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: a=%h act=%b rdy=%b rnw=%b ack=%b rd=%h tr=%h busy=%b, required 0000 0 1 1 00 00 00 0",
                     a_out, dma_active, cpu_ready, dma_r_nw, req_ack, req_data, to_ram, blk_busy);
        end
        rst = 1'b0;
        @(negedge clk);
        edge_n = 0;
        checks++;
        if (cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: rdy=%b act=%b, required 1 0", cpu_ready, dma_active);
        end
        $display("test_reset done");
    endtask

    task automatic test_block();
        int low = 0;
        int bad_rd = 0;
        int bad_wr = 0;
        logic [15:0] exp_a;
        if (edge_n % 2 == 1) tick();
        blk_page = 8'h02;
        blk_trig = 1'b1;
        tick();
        blk_trig = 1'b0;
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (cpu_ready !== 1'b0 || dma_active !== 1'b0 || blk_busy !== 1'b1) begin
            errors++;
            $display("FAIL blk_halt: rdy=%b act=%b busy=%b, required 0 0 1", cpu_ready, dma_active, blk_busy);
        end
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (cpu_ready !== 1'b0 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL blk_align: rdy=%b act=%b, required 0 0", cpu_ready, dma_active);
        end
        for (int k = 0; k < 256; k++) begin
            if (k == 50) begin
                blk_page = 8'h7F;
                blk_trig = 1'b1;
            end
            tick();
            blk_trig = 1'b0;
            if (cpu_ready === 1'b0) low++;
            exp_a = {8'h02, 8'(k)};
            checks++;
            if (a_out !== exp_a || dma_r_nw !== 1'b1 || dma_active !== 1'b1) begin
                errors++;
                bad_rd++;
                if (bad_rd < 4) $display("FAIL blk_read: a=%h rnw=%b act=%b, required %h 1 1", a_out, dma_r_nw, dma_active, exp_a);
            end
            tick();
            if (cpu_ready === 1'b0) low++;
            checks++;
            if (a_out !== 16'h2004 || dma_r_nw !== 1'b0 || to_ram !== ram_byte(exp_a)) begin
                errors++;
                bad_wr++;
                if (bad_wr < 4) $display("FAIL blk_write: a=%h rnw=%b data=%h, required 2004 0 %h", a_out, dma_r_nw, to_ram, ram_byte(exp_a));
            end
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b1 || blk_busy !== 1'b0 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL blk_done: rdy=%b busy=%b act=%b, required 1 0 0", cpu_ready, blk_busy, dma_active);
        end
        checks++;
        if (low != 514) begin
            errors++;
            $display("FAIL blk_halt_cycles: got %0d, required 514", low);
        end
        tick();
        $display("test_block done: halted %0d cycles", low);
    endtask

    task automatic test_fetch();
        int low = 0;
        if (edge_n % 2 == 1) tick();
        req_addr = {16'h0000, 16'hC000};
        req = 2'b01;
        tick();
        if (cpu_ready === 1'b0) low++;
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (req_ack !== 2'b00 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL fetch_align: ack=%b act=%b, required 00 0", req_ack, dma_active);
        end
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (req_ack !== 2'b01 || a_out !== 16'hC000 || dma_r_nw !== 1'b1 || dma_active !== 1'b1) begin
            errors++;
            $display("FAIL fetch_read: ack=%b a=%h rnw=%b act=%b, required 01 c000 1 1", req_ack, a_out, dma_r_nw, dma_active);
        end
        req = 2'b00;
        tick();
        checks++;
        if (req_data !== 8'h5A || req_ack !== 2'b00 || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL fetch_done: data=%h ack=%b rdy=%b, required 5a 00 1", req_data, req_ack, cpu_ready);
        end
        checks++;
        if (low != 3) begin
            errors++;
            $display("FAIL fetch_halt_cycles: got %0d, required 3", low);
        end
        tick();
        $display("test_fetch done: data=%h", req_data);
    endtask

    task automatic test_preempt();
        int low = 0;
        int bad = 0;
        logic [15:0] exp_a;
        if (edge_n % 2 == 1) tick();
        blk_page = 8'h03;
        blk_trig = 1'b1;
        tick();
        blk_trig = 1'b0;
        if (cpu_ready === 1'b0) low++;
        tick();
        if (cpu_ready === 1'b0) low++;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (cpu_ready === 1'b0) low++;
            exp_a = {8'h03, 8'(k)};
            checks++;
            if (a_out !== exp_a || dma_r_nw !== 1'b1) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL pre_read: a=%h rnw=%b, required %h 1", a_out, dma_r_nw, exp_a);
            end
            if (k == 10) begin
                req_addr = {16'hC123, 16'h0000};
                req = 2'b10;
            end
            tick();
            if (cpu_ready === 1'b0) low++;
            checks++;
            if (a_out !== 16'h2004 || dma_r_nw !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL pre_write: a=%h rnw=%b, required 2004 0", a_out, dma_r_nw);
            end
            if (k == 10) begin
                tick();
                if (cpu_ready === 1'b0) low++;
                checks++;
                if (a_out !== 16'hC123 || req_ack !== 2'b10 || dma_r_nw !== 1'b1) begin
                    errors++;
                    $display("FAIL pre_fetch: a=%h ack=%b rnw=%b, required c123 10 1", a_out, req_ack, dma_r_nw);
                end
                req = 2'b00;
            end
        end
        tick();
        checks++;
        if (req_data !== 8'h3C || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_done: data=%h rdy=%b, required 3c 1", req_data, cpu_ready);
        end
        checks++;
        if (low != 515) begin
            errors++;
            $display("FAIL pre_halt_cycles: got %0d, required 515", low);
        end
        tick();
        $display("test_preempt done: halted %0d cycles", low);
    endtask

    task automatic test_priority();
        int low = 0;
        if (edge_n % 2 == 0) tick();
        req_addr = {16'hC123, 16'hC000};
        req = 2'b11;
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (req_ack !== 2'b00 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_halt: ack=%b rdy=%b, required 00 0", req_ack, cpu_ready);
        end
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (req_ack !== 2'b01 || a_out !== 16'hC000) begin
            errors++;
            $display("FAIL prio_ch0: ack=%b a=%h, required 01 c000", req_ack, a_out);
        end
        req[0] = 1'b0;
        tick();
        if (cpu_ready === 1'b0) low++;
        checks++;
        if (req_ack !== 2'b10 || a_out !== 16'hC123 || req_data !== 8'h5A) begin
            errors++;
            $display("FAIL prio_ch1: ack=%b a=%h data=%h, required 10 c123 5a", req_ack, a_out, req_data);
        end
        req[1] = 1'b0;
        tick();
        checks++;
        if (req_ack !== 2'b00 || req_data !== 8'h3C || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_done: ack=%b data=%h rdy=%b, required 00 3c 1", req_ack, req_data, cpu_ready);
        end
        checks++;
        if (low != 3) begin
            errors++;
            $display("FAIL prio_halt_cycles: got %0d, required 3", low);
        end
        tick();
        $display("test_priority done");
    endtask

    task automatic test_halt_wait();
        int bad = 0;
        logic [15:0] exp_a;
        if (edge_n % 2 == 1) tick();
        cpu_r_nw = 1'b0;
        blk_page = 8'h04;
        blk_trig = 1'b1;
        tick();
        blk_trig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cpu_ready !== 1'b0 || dma_active !== 1'b0 || a_out !== 16'h0) begin
                errors++;
                $display("FAIL halt_wait_%0d: rdy=%b act=%b a=%h, required 0 0 0000", i, cpu_ready, dma_active, a_out);
            end
            if (i < 2) tick();
        end
        cpu_r_nw = 1'b1;
        if (edge_n % 2 == 1) begin
            tick();
            checks++;
            if (dma_active !== 1'b0 || cpu_ready !== 1'b0) begin
                errors++;
                $display("FAIL halt_wait_align: act=%b rdy=%b, required 0 0", dma_active, cpu_ready);
            end
        end
        for (int k = 0; k < 256; k++) begin
            tick();
            exp_a = {8'h04, 8'(k)};
            checks++;
            if (a_out !== exp_a || dma_active !== 1'b1) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL hw_read: a=%h act=%b, required %h 1", a_out, dma_active, exp_a);
            end
            tick();
        end
        tick();
        cpu_r_nw = 1'b0;
        req_addr = {16'h0000, 16'hC000};
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
                errors++;
                $display("FAIL done_wait_%0d: rdy=%b act=%b, required 1 0", i, cpu_ready, dma_active);
            end
        end
        cpu_r_nw = 1'b1;
        tick();
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_exit_idle: rdy=%b, required 1", cpu_ready);
        end
        tick();
        checks++;
        if (cpu_ready !== 1'b0 || req_ack !== 2'b00) begin
            errors++;
            $display("FAIL done_exit_halt: rdy=%b ack=%b, required 0 00", cpu_ready, req_ack);
        end
        if (edge_n % 2 == 1) tick();
        tick();
        checks++;
        if (req_ack !== 2'b01 || a_out !== 16'hC000) begin
            errors++;
            $display("FAIL done_exit_fetch: ack=%b a=%h, required 01 c000", req_ack, a_out);
        end
        req = 2'b00;
        tick();
        tick();
        $display("test_halt_wait done");
    endtask

    task automatic test_reset_mid();
        if (edge_n % 2 == 1) tick();
        blk_page = 8'h05;
        blk_trig = 1'b1;
        tick();
        blk_trig = 1'b0;
        tick();
        for (int k = 0; k < 100; k++) begin
            tick();
            tick();
        end
        tick();
        checks++;
        if (a_out !== 16'h0564) begin
            errors++;
            $display("FAIL mid_pair100: a=%h, required 0564", a_out);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out !== 16'h0 || dma_active !== 1'b0 || cpu_ready !== 1'b1 || dma_r_nw !== 1'b1 ||
            req_ack !== 2'b00 || req_data !== 8'h0 || to_ram !== 8'h0 || blk_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_values: a=%h act=%b rdy=%b rnw=%b ack=%b rd=%h tr=%h busy=%b, required 0000 0 1 1 00 00 00 0",
                     a_out, dma_active, cpu_ready, dma_r_nw, req_ack, req_data, to_ram, blk_busy);
        end
        rst = 1'b0;
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dma_active !== 1'b0 || cpu_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_quiet_%0d: act=%b rdy=%b, required 0 1", i, dma_active, cpu_ready);
            end
        end
        blk_page = 8'h06;
        blk_trig = 1'b1;
        tick();
        blk_trig = 1'b0;
        tick();
        tick();
        checks++;
        if (a_out !== 16'h0600 || dma_active !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart_0: a=%h act=%b, required 0600 1", a_out, dma_active);
        end
        tick();
        tick();
        checks++;
        if (a_out !== 16'h0601) begin
            errors++;
            $display("FAIL mid_restart_1: a=%h, required 0601", a_out);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_n   = 0;
        rst      = 1'b1;
        cpu_clk  = 1'b0;
        blk_trig = 1'b0;
        blk_page = 8'h00;
        req      = 2'b00;
        req_addr = 32'h0;
        cpu_r_nw = 1'b1;
        test_reset();
        test_block();
        test_fetch();
        test_preempt();
        test_priority();
        test_halt_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
